// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer.
// Contents: one-hot sequencer state encoding, PC width, instruction size.
package pc_seq_pkg;

    localparam int PC_W        = 8;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        RUN   = 5'b00010,
        STEP  = 5'b00100,
        DONE  = 5'b01000,
        FAULT = 5'b10000
    } seq_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for the sequencer.
// Ports:
//   read_addr    in  PC_W  current PC
//   se_imm       in  32    sign-extended immediate (only [5:0] is used)
//   jump_value   in  26    jump field (only [5:0] is used)
//   zero         in  1     ALU zero flag
//   branch       in  1     branch control
//   jump         in  1     jump control
//   target       out PC_W  selected next address (modulo 256)
//   is_self_jump out 1     jump whose target equals the current PC
//   out_of_range out 1     target lies at or beyond IMEM_BYTES
module pc_next_calc
    import pc_seq_pkg::*;
#(
    parameter int IMEM_BYTES = 128
) (
    input  logic [PC_W-1:0] read_addr,
    input  logic [31:0]     se_imm,
    input  logic [25:0]     jump_value,
    input  logic            zero,
    input  logic            branch,
    input  logic            jump,
    output logic [PC_W-1:0] target,
    output logic            is_self_jump,
    output logic            out_of_range
);

    logic [PC_W-1:0] pc4;
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] jump_target;

    // The 8-bit address space only sees the low six bits of either field.
    logic unused_bits;
    assign unused_bits = ^{se_imm[31:6], jump_value[25:6]};

    assign pc4           = read_addr + PC_W'(INSTR_BYTES);
    assign branch_target = pc4 + {se_imm[5:0], 2'b00};
    assign jump_target   = {jump_value[5:0], 2'b00};

    always_comb begin
        target = pc4;
        if (jump) begin
            target = jump_target;
        end else if (branch && zero) begin
            target = branch_target;
        end
    end

    assign is_self_jump = jump && (target == read_addr);
    // Widened compare so IMEM_BYTES=256 never faults.
    assign out_of_range = 32'(target) >= IMEM_BYTES;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and run/step/stop fetch sequencer in front of the MIPS core.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   run, step, stop    level-sampled execution controls
//   SEImm, JumpValue,
//   Zero, Branch, Jump core outputs used to choose the next PC
//   ReadAddr           registered PC driven to the core
//   commit             current instruction retires at the next edge
//   running            state is RUN or STEP
//   done, fault        terminal states (self-jump / out-of-range target)
//   instr_count        saturating retired-instruction counter
//
// state | meaning
// IDLE  | PC held, waiting for run or step
// RUN   | retire every cycle until stop
// STEP  | retire one instruction, then back to IDLE
// DONE  | program finished with a jump-to-self; only reset leaves
// FAULT | target beyond instruction memory; only reset leaves
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 8'h00,
    parameter int              IMEM_BYTES = 128,
    parameter int              CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             stop,
    input  logic [31:0]      SEImm,
    input  logic [25:0]      JumpValue,
    input  logic             Zero,
    input  logic             Branch,
    input  logic             Jump,
    output logic [PC_W-1:0]  ReadAddr,
    output logic             commit,
    output logic             running,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    seq_state_t      state;
    seq_state_t      state_next;
    logic            pc_load;
    logic [PC_W-1:0] target;
    logic            is_self_jump;
    logic            out_of_range;

    pc_next_calc #(
        .IMEM_BYTES(IMEM_BYTES)
    ) u_next (
        .read_addr    (ReadAddr),
        .se_imm       (SEImm),
        .jump_value   (JumpValue),
        .zero         (Zero),
        .branch       (Branch),
        .jump         (Jump),
        .target       (target),
        .is_self_jump (is_self_jump),
        .out_of_range (out_of_range)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        pc_load    = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_next = RUN;
                end else if (step) begin
                    state_next = STEP;
                end
            end
            RUN, STEP: begin
                if (state == RUN && stop) begin
                    state_next = IDLE;
                end else if (out_of_range) begin
                    state_next = FAULT;
                end else if (is_self_jump) begin
                    commit     = 1'b1;
                    state_next = DONE;
                end else begin
                    commit     = 1'b1;
                    pc_load    = 1'b1;
                    state_next = (state == STEP) ? IDLE : RUN;
                end
            end
            DONE:    state_next = DONE;
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ReadAddr    <= RESET_PC;
            instr_count <= '0;
        end else begin
            if (pc_load) begin
                ReadAddr <= target;
            end
            if (commit && (instr_count != {CNT_W{1'b1}})) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    assign running = (state == RUN) || (state == STEP);
    assign done    = (state == DONE);
    assign fault   = (state == FAULT);

endmodule
